display_scan_mux: RTL and testbench

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

---
 rtl/display_pkg.sv | 21 ++
 rtl/scan_timer.sv | 39 +++
 rtl/display_scan_mux.sv | 109 ++++++++++
 tb/tb_display_scan_mux.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 4-digit display scanner.
package display_pkg;

    localparam int unsigned DIGIT_COUNT = 4;

    typedef enum logic {
        DEAD,
        DRIVE
    } scan_state_e;

    typedef logic [1:0] digit_idx_t;

    // Active-low anode pattern with only the selected digit enabled.
    function automatic logic [DIGIT_COUNT-1:0] anode_sel(input digit_idx_t idx);
        logic [DIGIT_COUNT-1:0] onehot;
        onehot = '0;
        onehot[idx] = 1'b1;
        return ~onehot;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Per-slot cycle counter with terminal-count decode for the dead and drive phases.
module scan_timer #(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_start,
    output logic dead_done,
    output logic slot_done
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (slot_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign slot_start = (cnt_q == '0);
    assign dead_done  = (cnt_q == DEAD_LAST);
    assign slot_done  = (cnt_q == SLOT_LAST);

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit time display scanner: dead-time separated anode multiplexing with
// per-frame input capture, digit blanking and colon drive, all outputs registered.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            digits_in,
    input  logic [DIGIT_COUNT-1:0] blank_mask,
    input  logic                   lz_blank,
    input  logic                   colon_en,
    output logic [3:0]             digit_code,
    output logic [DIGIT_COUNT-1:0] an_n,
    output logic                   colon,
    output logic                   frame_start
);

    scan_state_e state_q, state_d;
    digit_idx_t  idx_q, idx_d;
    logic [15:0] frame_q, frame_d;

    logic [3:0]             digit_code_d;
    logic [DIGIT_COUNT-1:0] an_n_d;
    logic                   colon_d;
    logic                   frame_start_d;

    logic slot_start;
    logic dead_done;
    logic slot_done;
    logic capture;
    logic blanked;

    scan_timer #(
        .SCAN_DIV    (SCAN_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_scan_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .slot_start (slot_start),
        .dead_done  (dead_done),
        .slot_done  (slot_done)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            DEAD: begin
                if (dead_done) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (slot_done) begin
                    state_d = DEAD;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = DEAD;
            end
        endcase
    end

    // The output registers present the cycle the FSM is in now, so a capture made at
    // this edge must feed digit_code and the leading-zero test at the same edge.
    always_comb begin
        capture = (state_q == DEAD) && slot_start && (idx_q == 2'd0);
        frame_d = capture ? digits_in : frame_q;

        blanked = blank_mask[idx_q] ||
                  ((idx_q == 2'd3) && lz_blank && (frame_d[15:12] == 4'h0));

        digit_code_d  = frame_d[{idx_q, 2'b00} +: 4];
        frame_start_d = capture;
        an_n_d        = '1;
        colon_d       = 1'b0;
        if (state_q == DRIVE) begin
            if (!blanked) begin
                an_n_d = anode_sel(idx_q);
            end
            colon_d = (idx_q == 2'd2) && colon_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= DEAD;
            idx_q       <= 2'd0;
            frame_q     <= 16'h0000;
            digit_code  <= 4'h0;
            an_n        <= '1;
            colon       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            digit_code  <= digit_code_d;
            an_n        <= an_n_d;
            colon       <= colon_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: table-driven frame scenarios, hand-written corner
// sequences and a long randomized run against a cycle-position reference model.
module tb_display_scan_mux;

    localparam int unsigned SD = 8;
    localparam int unsigned DC = 2;
    localparam int unsigned FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] dig = 16'h0000;
    logic [3:0]  bm = 4'h0;
    logic        lz = 1'b0;
    logic        ce = 1'b0;

    logic [3:0] digit_code;
    logic [3:0] an_n;
    logic       colon;
    logic       frame_start;

    int total = 0;
    int bad = 0;

    // reference model state: t counts cycles since the last reset release
    int          t = 0;
    int          m_pos = -1;
    int          m_slot = -1;
    logic [15:0] fm = 16'h0000;

    int         last_lit = -1;
    int         off_run = 0;
    logic [3:0] prev_dc = 4'h0;

    always #5 clk = ~clk;

    display_scan_mux #(
        .SCAN_DIV    (SD),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .rst_n       (rstn),
        .digits_in   (dig),
        .blank_mask  (bm),
        .lz_blank    (lz),
        .colon_en    (ce),
        .digit_code  (digit_code),
        .an_n        (an_n),
        .colon       (colon),
        .frame_start (frame_start)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
        end
    endtask

    // One clock: sample #1 after the edge, advance the model with the inputs that
    // were stable at that edge, then compare every output and invariant.
    task automatic tick();
        logic [3:0] e_dc;
        logic [3:0] e_an;
        logic       e_col;
        logic       e_fs;
        logic       blanked;
        int         lit;
        @(posedge clk);
        #1;
        if (!rstn) begin
            e_dc = 4'h0; e_an = 4'hF; e_col = 1'b0; e_fs = 1'b0;
            fm = 16'h0000; t = 0; m_pos = -1; m_slot = -1;
        end else begin
            m_pos  = t % SD;
            m_slot = (t / SD) % 4;
            if (t % FRAME == 0) fm = dig;
            e_dc    = fm[m_slot*4 +: 4];
            blanked = bm[m_slot] || (m_slot == 3 && lz && fm[15:12] == 4'h0);
            e_an    = (m_pos >= DC && !blanked) ? ~(4'b0001 << m_slot) : 4'hF;
            e_col   = (m_pos >= DC) && (m_slot == 2) && ce;
            e_fs    = (t % FRAME == 0);
            t++;
        end
        chk("digit_code", digit_code, e_dc);
        chk("an_n", an_n, e_an);
        chk("colon", colon, e_col);
        chk("frame_start", frame_start, e_fs);

        chk("one_anode", $countones(~an_n) <= 1, 1'b1);
        chk("code_hold", (digit_code == prev_dc) || m_pos <= 0, 1'b1);
        prev_dc = digit_code;
        if (an_n != 4'hF) begin
            lit = 0;
            for (int i = 0; i < 4; i++) if (!an_n[i]) lit = i;
            if (last_lit >= 0 && lit != last_lit) chk("anode_gap", off_run >= DC, 1'b1);
            last_lit = lit;
            off_run = 0;
        end else begin
            off_run++;
        end
    endtask

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  blank;
        logic        lz;
        logic        ce;
        logic [15:0] exp_codes;
        logic [3:0]  exp_lit;
        int          exp_colon;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [15:0] codes;
        logic [3:0]  litm;
        int          ncol;
        int          nfs;
        logic [3:0]  exp_seq[8];
        logic [3:0]  seen[8];

        vecs[0] = '{16'h1234, 4'b0000, 1'b0, 1'b0, 16'h1234, 4'b1111, 0};
        vecs[1] = '{16'h0959, 4'b0000, 1'b1, 1'b0, 16'h0959, 4'b0111, 0};
        vecs[2] = '{16'h1959, 4'b0000, 1'b1, 1'b0, 16'h1959, 4'b1111, 0};
        vecs[3] = '{16'h0959, 4'b0000, 1'b0, 1'b0, 16'h0959, 4'b1111, 0};
        vecs[4] = '{16'h5678, 4'b0100, 1'b0, 1'b1, 16'h5678, 4'b1011, 6};
        vecs[5] = '{16'hABCF, 4'b0000, 1'b0, 1'b1, 16'hABCF, 4'b1111, 6};
        vecs[6] = '{16'hFEDC, 4'b1001, 1'b1, 1'b1, 16'hFEDC, 4'b0110, 6};
        vecs[7] = '{16'h0000, 4'b0000, 1'b1, 1'b0, 16'h0000, 4'b0111, 0};

        // reset state straight from power-up
        rstn = 1'b0;
        tick();
        tick();

        for (int v = 0; v < 8; v++) begin
            dig = vecs[v].digits; bm = vecs[v].blank; lz = vecs[v].lz; ce = vecs[v].ce;
            rstn = 1'b0;
            tick();
            rstn = 1'b1;
            codes = 16'h0; litm = 4'h0; ncol = 0; nfs = 0;
            for (int c = 0; c < FRAME; c++) begin
                tick();
                if (m_pos == 4) begin
                    codes[m_slot*4 +: 4] = digit_code;
                    litm[m_slot] = (an_n != 4'hF);
                end
                ncol += int'(colon);
                nfs  += int'(frame_start);
            end
            chk("vec_codes", codes, vecs[v].exp_codes);
            chk("vec_lit", litm, vecs[v].exp_lit);
            chk("vec_colon_cycles", 16'(ncol), 16'(vecs[v].exp_colon));
            chk("vec_frame_starts", 16'(nfs), 16'd1);
        end

        // inputs changed mid-frame appear only from the next frame on
        exp_seq[0] = 4'h4; exp_seq[1] = 4'h3; exp_seq[2] = 4'h2; exp_seq[3] = 4'h1;
        exp_seq[4] = 4'h9; exp_seq[5] = 4'h5; exp_seq[6] = 4'h9; exp_seq[7] = 4'h0;
        dig = 16'h1234; bm = 4'h0; lz = 1'b0; ce = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            if (c == 10) dig = 16'h0959;
            if (m_pos == 4) seen[m_slot + 4 * (c / FRAME)] = digit_code;
        end
        for (int k = 0; k < 8; k++) chk("midframe_code", seen[k], exp_seq[k]);

        // one-cycle reset during digit-2 drive aborts the slot
        dig = 16'h4321; ce = 1'b1;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int c = 0; c <= 2 * SD + 4; c++) tick();
        chk("pre_reset_colon", colon, 1'b1);
        chk("pre_reset_an", an_n, 4'b1011);
        dig = 16'h8765;
        rstn = 1'b0;
        tick();
        chk("reset_an", an_n, 4'hF);
        chk("reset_colon", colon, 1'b0);
        rstn = 1'b1;
        tick();
        chk("release_fs", frame_start, 1'b1);
        chk("release_code", digit_code, 4'h5);

        // long random run
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(15) == 0) dig = 16'($urandom);
            if ($urandom_range(31) == 0) bm = 4'($urandom);
            if ($urandom_range(31) == 0) lz = 1'($urandom);
            if ($urandom_range(15) == 0) ce = 1'($urandom);
            rstn = ($urandom_range(499) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
